// File: rtl/ac_e_register_unit.sv
// AC/E register stage: 1-cycle load/clear/increment of AC and E plus a registered skip request.
// Optional sticky AC increment-wrap flag when INR_WRAP_FLAG_EN is defined; no backpressure.
module ac_e_register_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] alu_outdata,
   input  logic             e_indata,
   input  logic             ff_en,
   input  logic             ac_ld,
   input  logic             ac_clr,
   input  logic             ac_inr,
   input  logic             e_clr,
   input  logic [3:0]       skip_sel,
   output logic [WIDTH-1:0] ac_outdata,
   output logic             e_outdata,
   output logic             skip_req
`ifdef INR_WRAP_FLAG_EN
   ,
   output logic             inr_wrap
`endif
);

   logic [WIDTH-1:0] ac_q, ac_d;
   logic             e_q, e_d;
   logic             skip_q, skip_d;

   always_comb begin
      ac_d = ac_q;
      if (ac_clr)      ac_d = '0;
      else if (ac_ld)  ac_d = alu_outdata;
      else if (ac_inr) ac_d = ac_q + WIDTH'(1);
   end

   always_comb begin
      e_d = e_q;
      if (e_clr)      e_d = 1'b0;
      else if (ff_en) e_d = e_indata;
   end

   // Skip tests look at the pre-edge AC/E, so a same-cycle write is not seen.
   always_comb begin
      skip_d = (skip_sel[3] & ~ac_q[WIDTH-1])
             | (skip_sel[2] &  ac_q[WIDTH-1])
             | (skip_sel[1] & (ac_q == '0))
             | (skip_sel[0] & ~e_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ac_q   <= '0;
         e_q    <= 1'b0;
         skip_q <= 1'b0;
      end else begin
         ac_q   <= ac_d;
         e_q    <= e_d;
         skip_q <= skip_d;
      end
   end

   assign ac_outdata = ac_q;
   assign e_outdata  = e_q;
   assign skip_req   = skip_q;

`ifdef INR_WRAP_FLAG_EN
   logic wrap_q, wrap_d;

   // Only an increment that actually wins the AC priority can set the flag.
   always_comb begin
      wrap_d = wrap_q;
      if (ac_clr)                                   wrap_d = 1'b0;
      else if (!ac_ld && ac_inr && (ac_q == '1))    wrap_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) wrap_q <= 1'b0;
      else        wrap_q <= wrap_d;
   end

   assign inr_wrap = wrap_q;
`endif

endmodule
